// File: rtl/nms_pkg.sv
// Shared defaults, angle codes and FSM encoding for the nonMax column feeder.
package nms_pkg;

    localparam int DEF_IMG_WIDTH  = 960;
    localparam int DEF_IMG_HEIGHT = 720;
    localparam int DEF_BIT_LENGTH = 5;

    localparam logic [1:0] ANG_0   = 2'b00;
    localparam logic [1:0] ANG_45  = 2'b01;
    localparam logic [1:0] ANG_90  = 2'b10;
    localparam logic [1:0] ANG_135 = 2'b11;

    typedef enum logic [1:0] {
        ST_FILL   = 2'b00,
        ST_STREAM = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

endpackage

// File: rtl/nms_line_buf.sv
// Single-port line buffer: combinational read of the addressed entry, write on the clock edge,
// so a read and write to the same address in one cycle returns the old contents.
module nms_line_buf #(
    parameter int DEPTH = 960,
    parameter int WIDTH = 5,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rd_data = mem_q[addr];

    // Storage write; contents deliberately survive reset and are overwritten on refill.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/nms_col_feeder.sv
// Turns the raster gradient/angle stream into 3-row columns for nonMax, owning the line
// buffers, row/column counters and the nonMax enable.
module nms_col_feeder
    import nms_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int BIT_LENGTH = DEF_BIT_LENGTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [BIT_LENGTH-1:0] pixel_in,
    input  logic [1:0]            angle_in,
    output logic [BIT_LENGTH-1:0] pixel_out0,
    output logic [BIT_LENGTH-1:0] pixel_out1,
    output logic [BIT_LENGTH-1:0] pixel_out2,
    output logic [1:0]            angle_out,
    output logic                  enable,
    output logic                  done,
    output logic                  err
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_FIRST_OUT = RW'(2);

    state_e                state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [1:0]            prev_ang_q, prev_ang_d;
    logic [BIT_LENGTH-1:0] pix0_q, pix0_d, pix1_q, pix1_d, pix2_q, pix2_d;
    logic [1:0]            angle_q, angle_d;
    logic                  enable_q, enable_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  accept_s;
    logic                  emit_s;
    logic [BIT_LENGTH-1:0] lb0_rd_s;
    logic [BIT_LENGTH+1:0] lb1_rd_s;

    assign accept_s = in_valid && !reset && (state_q != ST_DONE);

    // LB0: row y-2 pixels, refilled from the outgoing LB1 entry.
    nms_line_buf #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (BIT_LENGTH),
        .AW    (CW)
    ) u_lb0 (
        .clk     (clk),
        .we      (accept_s),
        .addr    (col_q),
        .wr_data (lb1_rd_s[BIT_LENGTH+1:2]),
        .rd_data (lb0_rd_s)
    );

    // LB1: row y-1 pixel and angle packed as {pixel, angle}.
    nms_line_buf #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (BIT_LENGTH + 2),
        .AW    (CW)
    ) u_lb1 (
        .clk     (clk),
        .we      (accept_s),
        .addr    (col_q),
        .wr_data ({pixel_in, angle_in}),
        .rd_data (lb1_rd_s)
    );

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        prev_ang_d = prev_ang_q;
        pix0_d     = {BIT_LENGTH{1'b0}};
        pix1_d     = {BIT_LENGTH{1'b0}};
        pix2_d     = {BIT_LENGTH{1'b0}};
        angle_d    = ANG_0;
        enable_d   = 1'b0;
        done_d     = done_q;
        err_d      = err_q;
        emit_s     = 1'b0;

        if (accept_s) begin
            prev_ang_d = lb1_rd_s[1:0];
            if (col_q == COL_LAST) begin
                col_d = {CW{1'b0}};
                if (row_q == ROW_LAST) begin
                    row_d = {RW{1'b0}};
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end else begin
            prev_ang_d = prev_ang_q;
        end

        case (state_q)
            ST_FILL: begin
                if (accept_s && (row_q == ROW_FIRST_OUT)) begin
                    emit_s  = 1'b1;
                    state_d = ST_STREAM;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_STREAM: begin
                if (accept_s) begin
                    emit_s = 1'b1;
                    if ((row_q == ROW_LAST) && (col_q == COL_LAST)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    // nonMax cannot stall, so any gap mid-frame aborts the frame.
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Entered cleanly (no err) means the last column was just shown.
                done_d = done_q | ~err_q;
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

        if (emit_s) begin
            pix0_d   = lb0_rd_s;
            pix1_d   = lb1_rd_s[BIT_LENGTH+1:2];
            pix2_d   = pixel_in;
            angle_d  = (col_q == {CW{1'b0}}) ? ANG_0 : prev_ang_q;
            enable_d = 1'b1;
        end else begin
            enable_d = 1'b0;
        end
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_FILL;
            col_q      <= {CW{1'b0}};
            row_q      <= {RW{1'b0}};
            prev_ang_q <= 2'b00;
            pix0_q     <= {BIT_LENGTH{1'b0}};
            pix1_q     <= {BIT_LENGTH{1'b0}};
            pix2_q     <= {BIT_LENGTH{1'b0}};
            angle_q    <= 2'b00;
            enable_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            prev_ang_q <= prev_ang_d;
            pix0_q     <= pix0_d;
            pix1_q     <= pix1_d;
            pix2_q     <= pix2_d;
            angle_q    <= angle_d;
            enable_q   <= enable_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign pixel_out0 = pix0_q;
    assign pixel_out1 = pix1_q;
    assign pixel_out2 = pix2_q;
    assign angle_out  = angle_q;
    assign enable     = enable_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_nms_col_feeder.sv
// Directed scoreboard bench for nms_col_feeder on a 4x4 frame.
module tb_nms_col_feeder;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int BL = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [BL-1:0] pixel_in;
    logic [1:0]    angle_in;
    logic [BL-1:0] pixel_out0, pixel_out1, pixel_out2;
    logic [1:0]    angle_out;
    logic          enable, done, err;

    int          checks   = 0;
    int          errors   = 0;
    int          en_count = 0;
    logic [16:0] sb [$];
    logic        exp_done;
    logic        exp_err;
    logic        live;

    nms_col_feeder #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .BIT_LENGTH (BL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .pixel_in   (pixel_in),
        .angle_in   (angle_in),
        .pixel_out0 (pixel_out0),
        .pixel_out1 (pixel_out1),
        .pixel_out2 (pixel_out2),
        .angle_out  (angle_out),
        .enable     (enable),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic logic [BL-1:0] pix(input int r, input int c);
        return BL'((W * r + c) % 32);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, push the expected column if this pixel is a streaming accept, then check.
    task automatic tick(input logic v, input int r, input int c, input logic rst);
        logic [16:0] e;
        logic        exp_en;
        reset    = rst;
        in_valid = v;
        pixel_in = pix(r, c);
        angle_in = 2'(c);
        if (rst) begin
            sb.delete();
            live     = 1'b1;
            exp_done = 1'b0;
            exp_err  = 1'b0;
            en_count = 0;
        end else if (v && live && r >= 2) begin
            sb.push_back({pix(r - 2, c), pix(r - 1, c), pix(r, c),
                          (c == 0) ? 2'b00 : 2'(c - 1)});
        end
        @(posedge clk);
        #1;
        exp_en = (sb.size() != 0);
        if (enable === 1'b1) en_count++;
        chk("enable", {31'd0, enable}, {31'd0, exp_en});
        if (exp_en) begin
            e = sb.pop_front();
            chk("out0", {27'd0, pixel_out0}, {27'd0, e[16:12]});
            chk("out1", {27'd0, pixel_out1}, {27'd0, e[11:7]});
            chk("out2", {27'd0, pixel_out2}, {27'd0, e[6:2]});
            chk("angle", {30'd0, angle_out}, {30'd0, e[1:0]});
        end else begin
            chk("idle_out", {15'd0, pixel_out0, pixel_out1, pixel_out2, angle_out}, 32'd0);
        end
        chk("done", {31'd0, done}, {31'd0, exp_done});
        chk("err", {31'd0, err}, {31'd0, exp_err});
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        pixel_in = '0;
        angle_in = '0;
        live     = 1'b1;
        exp_done = 1'b0;
        exp_err  = 1'b0;

        // Basic gapless frame, then frame end and ignored input in DONE.
        tick(1'b0, 0, 0, 1'b1);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                tick(1'b1, r, c, 1'b0);
        live     = 1'b0;
        exp_done = 1'b1;
        tick(1'b0, 0, 0, 1'b0);
        chk("frame_en_count", en_count, 8);
        for (int k = 0; k < 3; k++)
            tick(1'b1, 3, k, 1'b0);

        // Gaps during FILL (inside row 1) are harmless.
        tick(1'b0, 0, 0, 1'b1);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                tick(1'b1, r, c, 1'b0);
                if (r == 1 && c == 1)
                    for (int k = 0; k < 3; k++)
                        tick(1'b0, 0, 0, 1'b0);
            end
        live     = 1'b0;
        exp_done = 1'b1;
        tick(1'b0, 0, 0, 1'b0);
        chk("fill_gap_en_count", en_count, 8);

        // Gap while streaming at row 3 col 1 aborts with err.
        tick(1'b0, 0, 0, 1'b1);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < W; c++)
                tick(1'b1, r, c, 1'b0);
        tick(1'b1, 3, 0, 1'b0);
        live    = 1'b0;
        exp_err = 1'b1;
        tick(1'b0, 0, 0, 1'b0);
        tick(1'b1, 3, 1, 1'b0);
        tick(1'b1, 3, 2, 1'b0);
        chk("gap_en_count", en_count, 5);

        // Reset in the middle of row 2 (with in_valid high), then a clean replay.
        tick(1'b0, 0, 0, 1'b1);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < W; c++)
                tick(1'b1, r, c, 1'b0);
        tick(1'b1, 2, 0, 1'b0);
        tick(1'b1, 2, 1, 1'b0);
        tick(1'b1, 2, 2, 1'b1);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                tick(1'b1, r, c, 1'b0);
        live     = 1'b0;
        exp_done = 1'b1;
        tick(1'b0, 0, 0, 1'b0);
        chk("replay_en_count", en_count, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
